dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Segment scheduler that sequences the `dds` frequency synthesizer for OFDM preamble, pilot-tone and chirp generation. It accepts segment commands over a valid/ready interface and double-buffers one pending command so that consecutive segments run without gaps. It drives the DDS frequency and phase-offset inputs, and emits sample-valid, start-of-segment and end-of-segment flags delayed to line up with the DDS output samples.

## Interface
- `pFR_W`, 32: frequency word width; equals the DDS `pFR_W`.
- `pPH_W`, 15: phase-offset width; equals the DDS `pPH_W`.
- `pLEN_W`, 16: segment length field width, in samples.
- `pDDS_LAT`, 7: cycles from a frequency word presented at `odds_freq` to the matching sample at the DDS output.
- `iclk`  in  1: single clock.
- `ireset_n`  in  1: reset, asynchronous, active-low.
- `iclkena`  in  1: global clock enable; when low, all state holds.
- `iabort`  in  1: synchronous flush of the running segment, the pending segment and in-flight flags.
- `icmd_val`  in  1: command valid.
- `ocmd_rdy`  out  1: command ready; high when the pending buffer is empty.
- `icmd_freq`  in  pFR_W: start frequency word.
- `icmd_step`  in  pFR_W: per-sample frequency increment, two's complement. Present only with CHIRP_EN.
- `icmd_len`  in  pLEN_W: number of samples in the segment.
- `icmd_ph_cos`  in  pPH_W: cosine phase offset for the segment.
- `icmd_ph_sin`  in  pPH_W: sine phase offset for the segment.
- `odds_clkena`  out  1: DDS clock enable; equals `iclkena`.
- `odds_freq`  out  pFR_W: DDS `ifreq`.
- `odds_ph_cos`  out  pPH_W: DDS `iph_cos`.
- `odds_ph_sin`  out  pPH_W: DDS `iph_sin`.
- `ovalid`  out  1: DDS output sample belongs to a segment.
- `osop`  out  1: first sample of a segment.
- `oeop`  out  1: last sample of a segment.
- `obusy`  out  1: a segment is running, or flags are still in the alignment pipe.

## Operation
- All behaviour below applies only on `iclkena`-qualified edges.
- **Command acceptance:** a command is accepted on an edge where `icmd_val` and `ocmd_rdy` are both high.
  - It loads into the pending buffer.
  - `ocmd_rdy` drops on the next cycle and rises again when the buffer is consumed.
- **Zero length:** a command with `icmd_len` = 0 is accepted and discarded. It produces no samples and no flags.
- **FSM states:** IDLE and RUN.
- **IDLE → RUN:** taken when the pending buffer is valid.
  - The pending command moves into the active registers.
  - `odds_freq`, `odds_ph_cos` and `odds_ph_sin` load the command values.
  - The sample counter loads `len-1`.
  - One issue flag is generated with sop set.
- **Each RUN cycle issues one sample:**
  - The counter decrements.
  - With CHIRP_EN, `odds_freq` ← `odds_freq + step`, modulo 2^pFR_W (wrap is legal, no saturation).
- **Last sample (counter = 0):** the issue flag carries eop. On the next edge:
  - If the pending buffer is valid, it loads directly and RUN continues with sop. There is no idle cycle.
  - Otherwise the FSM returns to IDLE and `odds_freq` holds its last value, so the DDS keeps running at the last tone.
- **Pending fill during hand-over:** a command accepted on the edge where the pending buffer is being consumed is legal and is stored.
- **Alignment pipe:** the issue flags (valid, sop, eop) pass through a `pDDS_LAT`-deep shift register to become `ovalid`, `osop` and `oeop`.
- **Single-sample segment (`len` = 1):** sop and eop are set on the same sample.
- **Abort:** `iabort` wins over everything else. On the next edge:
  - The FSM goes to IDLE.
  - The pending buffer is cleared and `ocmd_rdy` is high.
  - The whole alignment pipe is cleared, so `ovalid` is low.
  - `odds_freq` is held.
  - A command presented in the same cycle as `iabort` is dropped.
- **`obusy`:** equals the FSM being in RUN, OR'd with any valid bit set in the alignment pipe.

## Timing
- **Reset values:**
  - `odds_freq`, `odds_ph_cos`, `odds_ph_sin` = 0.
  - `ovalid`, `osop`, `oeop`, `obusy` = 0.
  - `ocmd_rdy` = 1.
  - FSM = IDLE.
- Reset clears the pipe immediately. Releasing reset mid-stream produces no stray flags.
- Command accepted at edge N with FSM in IDLE:
  - `odds_freq` holds the start frequency from cycle N+2.
  - `ovalid` and `osop` go high at cycle N+2+`pDDS_LAT`.
- Back-to-back segments produce contiguous `ovalid`: eop of segment A is immediately followed by sop of segment B.
- `iclkena` low freezes the FSM, counter, pending buffer and alignment pipe. `ocmd_rdy` holds its value.

## Configuration
- **`DDS_SWEEP_CTRL_CHIRP_EN` defined:**
  - The `icmd_step` port and the step registers exist.
  - The frequency is incremented on every sample, giving linear chirp segments.
- **Not defined:**
  - No step port, no adder.
  - `odds_freq` is constant within a segment, giving pure frequency-hop / tone segments.

## Structure
- Package `dds_sweep_pkg` holds:
  - the `state_t` enum (IDLE, RUN);
  - the `seg_cmd_t` packed struct (freq, step, len, ph_cos, ph_sin);
  - the `issue_flag_t` struct (valid, sop, eop).
- Sub-module `dds_sweep_align`: a parameterized-depth shift register with synchronous clear, used for the flag pipe.

## Test plan
- **Single tone:** freq=0x0100_0000, len=4 → `ovalid` high for 4 cycles; `osop` on the first, `oeop` on the fourth; first sample at acceptance+2+7; `odds_freq` constant.
- **Chirp (CHIRP_EN):** freq=0x1000, step=0x10, len=3 → `odds_freq` = 0x1000, 0x1010, 0x1020, then held at 0x1020.
- **Back-to-back:** len=2 then len=1, both queued while running → 3 contiguous `ovalid` cycles; sop/eop on samples 1/2 and sop+eop on sample 3; `ocmd_rdy` low only while the pending buffer is full.
- **Zero length and wrap:**
  - len=0 → no `ovalid`, `ocmd_rdy` returns high next cycle.
  - freq=0xFFFF_FFF0, step=0x20 → second word 0x0000_0010.
- **Abort mid-segment:** len=100, `iabort` at sample 10 with a command pending → `ovalid` low next cycle, `obusy` low, `ocmd_rdy` high, no further flags.
- **Stall and reset:**
  - `iclkena` low for 5 cycles mid-segment → all outputs frozen, sample count still exactly `len`.
  - `ireset_n` asserted mid-segment → all outputs at reset values immediately.

Source files
------------

// File: rtl/dds_sweep_pkg.sv
// Shared types for the DDS segment scheduler.
// DDS_SWEEP_CTRL_CHIRP_EN adds the per-sample step field to seg_cmd_t.
package dds_sweep_pkg;

  localparam int unsigned FR_W  = 32;
  localparam int unsigned PH_W  = 15;
  localparam int unsigned LEN_W = 16;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_t;

  typedef struct packed {
    logic [FR_W-1:0]  freq;
`ifdef DDS_SWEEP_CTRL_CHIRP_EN
    logic [FR_W-1:0]  step;
`endif
    logic [LEN_W-1:0] len;
    logic [PH_W-1:0]  ph_cos;
    logic [PH_W-1:0]  ph_sin;
  } seg_cmd_t;

  typedef struct packed {
    logic valid;
    logic sop;
    logic eop;
  } issue_flag_t;

  localparam issue_flag_t FlagNone = '0;

  // Flag for the first sample of a segment; a one-sample segment is also its own last.
  function automatic issue_flag_t first_flag(input logic [LEN_W-1:0] len);
    issue_flag_t f;
    f.valid = 1'b1;
    f.sop   = 1'b1;
    f.eop   = (len == LEN_W'(1));
    return f;
  endfunction

endpackage

// File: rtl/dds_sweep_align.sv
// Fixed-depth shift register for the issue flags, lining them up with DDS output samples.
// Synchronous clear empties every stage at once.
module dds_sweep_align
  import dds_sweep_pkg::*;
#(
  parameter int unsigned Depth = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  issue_flag_t din,
  output issue_flag_t dout,
  output logic        any_valid
);

  issue_flag_t pipe_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) pipe_q[i] <= FlagNone;
    end else if (en) begin
      if (clr) begin
        for (int i = 0; i < int'(Depth); i++) pipe_q[i] <= FlagNone;
      end else begin
        pipe_q[0] <= din;
        for (int i = 1; i < int'(Depth); i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout = pipe_q[Depth-1];

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < int'(Depth); i++) any_valid = any_valid | pipe_q[i].valid;
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Segment scheduler driving the dds block, with one pending-command buffer for gapless hand-over.
// Define DDS_SWEEP_CTRL_CHIRP_EN for the icmd_step port and per-sample frequency stepping.
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int unsigned pFR_W    = FR_W,
  parameter int unsigned pPH_W    = PH_W,
  parameter int unsigned pLEN_W   = LEN_W,
  parameter int unsigned pDDS_LAT = 7
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              iclkena,
  input  logic              iabort,
  input  logic              icmd_val,
  output logic              ocmd_rdy,
  input  logic [pFR_W-1:0]  icmd_freq,
`ifdef DDS_SWEEP_CTRL_CHIRP_EN
  input  logic [pFR_W-1:0]  icmd_step,
`endif
  input  logic [pLEN_W-1:0] icmd_len,
  input  logic [pPH_W-1:0]  icmd_ph_cos,
  input  logic [pPH_W-1:0]  icmd_ph_sin,
  output logic              odds_clkena,
  output logic [pFR_W-1:0]  odds_freq,
  output logic [pPH_W-1:0]  odds_ph_cos,
  output logic [pPH_W-1:0]  odds_ph_sin,
  output logic              ovalid,
  output logic              osop,
  output logic              oeop,
  output logic              obusy
);

  state_t            state_q;
  seg_cmd_t          pend_q;
  logic              pend_vld_q;
  logic [pLEN_W-1:0] cnt_q;
  issue_flag_t       iss_q;
`ifdef DDS_SWEEP_CTRL_CHIRP_EN
  logic [pFR_W-1:0]  step_q;
`endif

  logic        cmd_acc;
  logic        take_pend;
  logic        advance;
  issue_flag_t pipe_out;
  logic        pipe_busy;

  assign ocmd_rdy = ~pend_vld_q;
  // Zero-length commands complete the handshake but never reach the buffer.
  assign cmd_acc   = icmd_val & ~pend_vld_q & (icmd_len != '0);
  assign take_pend = pend_vld_q & ((state_q == StIdle) | (cnt_q == '0));
  assign advance   = (state_q == StRun) & (cnt_q != '0);

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      cnt_q       <= '0;
      iss_q       <= FlagNone;
      odds_freq   <= '0;
      odds_ph_cos <= '0;
      odds_ph_sin <= '0;
`ifdef DDS_SWEEP_CTRL_CHIRP_EN
      step_q      <= '0;
`endif
    end else if (iclkena) begin
      if (iabort) begin
        // Frequency and phase registers hold so the DDS keeps its last tone.
        state_q    <= StIdle;
        pend_vld_q <= 1'b0;
        iss_q      <= FlagNone;
      end else begin
        if (take_pend) pend_vld_q <= 1'b0;
        if (cmd_acc) begin
          pend_vld_q    <= 1'b1;
          pend_q.freq   <= icmd_freq;
`ifdef DDS_SWEEP_CTRL_CHIRP_EN
          pend_q.step   <= icmd_step;
`endif
          pend_q.len    <= icmd_len;
          pend_q.ph_cos <= icmd_ph_cos;
          pend_q.ph_sin <= icmd_ph_sin;
        end

        if (take_pend) begin
          state_q     <= StRun;
          cnt_q       <= pend_q.len - LEN_W'(1);
          odds_freq   <= pend_q.freq;
          odds_ph_cos <= pend_q.ph_cos;
          odds_ph_sin <= pend_q.ph_sin;
`ifdef DDS_SWEEP_CTRL_CHIRP_EN
          step_q      <= pend_q.step;
`endif
          iss_q       <= first_flag(pend_q.len);
        end else if (advance) begin
          cnt_q       <= cnt_q - pLEN_W'(1);
`ifdef DDS_SWEEP_CTRL_CHIRP_EN
          odds_freq   <= odds_freq + step_q;
`endif
          iss_q.valid <= 1'b1;
          iss_q.sop   <= 1'b0;
          iss_q.eop   <= (cnt_q == pLEN_W'(1));
        end else begin
          state_q <= StIdle;
          iss_q   <= FlagNone;
        end
      end
    end
  end

  dds_sweep_align #(
    .Depth (pDDS_LAT)
  ) u_align (
    .clk       (iclk),
    .rst_n     (ireset_n),
    .en        (iclkena),
    .clr       (iabort),
    .din       (iss_q),
    .dout      (pipe_out),
    .any_valid (pipe_busy)
  );

  assign odds_clkena = iclkena;
  assign ovalid      = pipe_out.valid;
  assign osop        = pipe_out.sop;
  assign oeop        = pipe_out.eop;
  assign obusy       = (state_q == StRun) | iss_q.valid | pipe_busy;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl; chirp checks follow DDS_SWEEP_CTRL_CHIRP_EN.
module tb_dds_sweep_ctrl;

  localparam int unsigned FW = 32;
  localparam int unsigned PW = 15;
  localparam int unsigned LW = 16;

  logic          iclk = 1'b0;
  logic          ireset_n = 1'b0;
  logic          iclkena = 1'b1;
  logic          iabort = 1'b0;
  logic          icmd_val = 1'b0;
  logic          ocmd_rdy;
  logic [FW-1:0] icmd_freq = '0;
  logic [FW-1:0] icmd_step = '0;
  logic [LW-1:0] icmd_len = '0;
  logic [PW-1:0] icmd_ph_cos = '0;
  logic [PW-1:0] icmd_ph_sin = '0;
  logic          odds_clkena;
  logic [FW-1:0] odds_freq;
  logic [PW-1:0] odds_ph_cos;
  logic [PW-1:0] odds_ph_sin;
  logic          ovalid, osop, oeop, obusy;

  int total = 0;
  int bad = 0;

  dds_sweep_ctrl #(
    .pFR_W    (FW),
    .pPH_W    (PW),
    .pLEN_W   (LW),
    .pDDS_LAT (7)
  ) dut (
    .iclk        (iclk),
    .ireset_n    (ireset_n),
    .iclkena     (iclkena),
    .iabort      (iabort),
    .icmd_val    (icmd_val),
    .ocmd_rdy    (ocmd_rdy),
    .icmd_freq   (icmd_freq),
`ifdef DDS_SWEEP_CTRL_CHIRP_EN
    .icmd_step   (icmd_step),
`endif
    .icmd_len    (icmd_len),
    .icmd_ph_cos (icmd_ph_cos),
    .icmd_ph_sin (icmd_ph_sin),
    .odds_clkena (odds_clkena),
    .odds_freq   (odds_freq),
    .odds_ph_cos (odds_ph_cos),
    .odds_ph_sin (odds_ph_sin),
    .ovalid      (ovalid),
    .osop        (osop),
    .oeop        (oeop),
    .obusy       (obusy)
  );

  always #5 iclk = ~iclk;

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((obusy || !ocmd_rdy) && w < 300) begin
      tick();
      w++;
    end
    if (obusy || !ocmd_rdy) begin
      total++; bad++;
      $display("FAIL wait_idle: obusy=%0b rdy=%0b, want 0/1", obusy, ocmd_rdy);
    end
  endtask

  // Presents one command for a single edge; caller guarantees ocmd_rdy is high.
  task automatic send(input logic [FW-1:0] f, input logic [FW-1:0] s, input logic [LW-1:0] l,
                      input logic [PW-1:0] pc, input logic [PW-1:0] ps);
    icmd_val = 1'b1; icmd_freq = f; icmd_step = s; icmd_len = l;
    icmd_ph_cos = pc; icmd_ph_sin = ps;
    tick();
    icmd_val = 1'b0;
  endtask

  task automatic test_reset();
    ireset_n = 1'b0;
    tick(); tick();
    total++; if (ocmd_rdy !== 1'b1) begin bad++; $display("FAIL rst_rdy got %b want 1", ocmd_rdy); end
    total++; if ({ovalid, osop, oeop, obusy} !== 4'b0) begin
      bad++; $display("FAIL rst_flags got %b want 0000", {ovalid, osop, oeop, obusy}); end
    total++; if (odds_freq !== '0) begin bad++; $display("FAIL rst_freq got %h want 0", odds_freq); end
    total++; if ({odds_ph_cos, odds_ph_sin} !== '0) begin
      bad++; $display("FAIL rst_ph got %h/%h want 0", odds_ph_cos, odds_ph_sin); end
    ireset_n = 1'b1;
    tick();
    total++; if ({ovalid, obusy, ocmd_rdy} !== 3'b001) begin
      bad++; $display("FAIL rst_release got %b want 001", {ovalid, obusy, ocmd_rdy}); end
  endtask

  task automatic test_single_tone();
    int first = -1, nval = 0, nsop = 0, sop_at = -1, eop_at = -1, fbad = 0;
    wait_idle();
    send(32'h0100_0000, 32'h0, 16'd4, 15'h1234, 15'h0567);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        total++; if (odds_ph_cos !== 15'h1234) begin
          bad++; $display("FAIL tone_ph_cos got %h want 1234", odds_ph_cos); end
        total++; if (odds_ph_sin !== 15'h0567) begin
          bad++; $display("FAIL tone_ph_sin got %h want 0567", odds_ph_sin); end
        total++; if (obusy !== 1'b1) begin bad++; $display("FAIL tone_busy got %b want 1", obusy); end
      end
      if (ovalid) begin nval++; if (first < 0) first = k; end
      if (osop) begin nsop++; sop_at = k; end
      if (oeop) eop_at = k;
      if (odds_freq !== 32'h0100_0000) fbad++;
    end
    total++; if (first != 8) begin bad++; $display("FAIL tone_latency got %0d want 8", first); end
    total++; if (nval != 4) begin bad++; $display("FAIL tone_count got %0d want 4", nval); end
    total++; if (nsop != 1 || sop_at != 8) begin
      bad++; $display("FAIL tone_sop got n=%0d at %0d want 1 at 8", nsop, sop_at); end
    total++; if (eop_at != 11) begin bad++; $display("FAIL tone_eop got %0d want 11", eop_at); end
    total++; if (fbad != 0) begin bad++; $display("FAIL tone_freq_const got %0d bad want 0", fbad); end
    total++; if (obusy !== 1'b0) begin bad++; $display("FAIL tone_idle got %b want 0", obusy); end
  endtask

  task automatic test_chirp();
    logic [FW-1:0] exp_f [5];
`ifdef DDS_SWEEP_CTRL_CHIRP_EN
    exp_f = '{32'h1000, 32'h1010, 32'h1020, 32'h1020, 32'h1020};
`else
    exp_f = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000};
`endif
    wait_idle();
    send(32'h1000, 32'h10, 16'd3, 15'h0, 15'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (odds_freq !== exp_f[k]) begin
        bad++; $display("FAIL chirp_freq[%0d] got %h want %h", k, odds_freq, exp_f[k]); end
    end
    wait_idle();
    send(32'hFFFF_FFF0, 32'h20, 16'd2, 15'h0, 15'h0);
    tick();
    total++; if (odds_freq !== 32'hFFFF_FFF0) begin
      bad++; $display("FAIL wrap_first got %h want FFFFFFF0", odds_freq); end
    tick();
`ifdef DDS_SWEEP_CTRL_CHIRP_EN
    total++; if (odds_freq !== 32'h0000_0010) begin
      bad++; $display("FAIL wrap_second got %h want 00000010", odds_freq); end
`else
    total++; if (odds_freq !== 32'hFFFF_FFF0) begin
      bad++; $display("FAIL hop_second got %h want FFFFFFF0", odds_freq); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [20:0] v = '0, s = '0, e = '0;
    wait_idle();
    send(32'h0A00_0000, 32'h0, 16'd2, 15'h0, 15'h0);
    icmd_val = 1'b1; icmd_freq = 32'h0B00_0000; icmd_step = '0; icmd_len = 16'd1;
    total++; if (ocmd_rdy !== 1'b0) begin bad++; $display("FAIL b2b_rdy_full got %b want 0", ocmd_rdy); end
    tick();
    total++; if (ocmd_rdy !== 1'b1) begin bad++; $display("FAIL b2b_rdy_free got %b want 1", ocmd_rdy); end
    total++; if (odds_freq !== 32'h0A00_0000) begin
      bad++; $display("FAIL b2b_freq_a got %h want 0A000000", odds_freq); end
    tick();
    icmd_val = 1'b0;
    total++; if (ocmd_rdy !== 1'b0) begin bad++; $display("FAIL b2b_rdy_b got %b want 0", ocmd_rdy); end
    tick();
    total++; if (ocmd_rdy !== 1'b1) begin bad++; $display("FAIL b2b_rdy_rel got %b want 1", ocmd_rdy); end
    total++; if (odds_freq !== 32'h0B00_0000) begin
      bad++; $display("FAIL b2b_freq_b got %h want 0B000000", odds_freq); end
    for (int k = 4; k <= 20; k++) begin
      tick();
      v[k] = ovalid; s[k] = osop; e[k] = oeop;
    end
    total++; if (v[11:7] !== 5'b01110 || $countones(v) != 3) begin
      bad++; $display("FAIL b2b_valid got %b want contiguous 7..11=01110", v); end
    total++; if (s[10:8] !== 3'b101) begin bad++; $display("FAIL b2b_sop got %b want 101", s[10:8]); end
    total++; if (e[10:8] !== 3'b110) begin bad++; $display("FAIL b2b_eop got %b want 110", e[10:8]); end
  endtask

  task automatic test_zero_len();
    int nval = 0, nbusy = 0, fbad = 0;
    wait_idle();
    send(32'hDEAD_0000, 32'h0, 16'd0, 15'h0, 15'h0);
    total++; if (ocmd_rdy !== 1'b1) begin bad++; $display("FAIL zero_rdy got %b want 1", ocmd_rdy); end
    for (int k = 0; k < 15; k++) begin
      tick();
      if (ovalid) nval++;
      if (obusy) nbusy++;
      if (odds_freq !== 32'h0B00_0000) fbad++;
    end
    total++; if (nval != 0 || nbusy != 0) begin
      bad++; $display("FAIL zero_quiet got valid=%0d busy=%0d want 0/0", nval, nbusy); end
    total++; if (fbad != 0) begin bad++; $display("FAIL zero_freq_hold got %0d bad want 0", fbad); end
  endtask

  task automatic test_abort();
    int n = 0, w = 0, nval = 0, nbusy = 0, fbad = 0;
    wait_idle();
    send(32'h0ABC_0000, 32'h0, 16'd100, 15'h0, 15'h0);
    icmd_val = 1'b1; icmd_freq = 32'h5555_0000; icmd_len = 16'd5;
    tick(); tick();
    icmd_val = 1'b0;
    total++; if (ocmd_rdy !== 1'b0) begin bad++; $display("FAIL abort_pend got %b want 0", ocmd_rdy); end
    while (n < 10 && w < 100) begin
      tick(); w++;
      if (ovalid) n++;
    end
    total++; if (n != 10) begin bad++; $display("FAIL abort_reach got %0d samples want 10", n); end
    iabort = 1'b1; icmd_val = 1'b1; icmd_freq = 32'h7777_0000;
    tick();
    iabort = 1'b0; icmd_val = 1'b0;
    total++; if ({ovalid, osop, oeop, obusy} !== 4'b0) begin
      bad++; $display("FAIL abort_flags got %b want 0000", {ovalid, osop, oeop, obusy}); end
    total++; if (ocmd_rdy !== 1'b1) begin bad++; $display("FAIL abort_rdy got %b want 1", ocmd_rdy); end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ovalid) nval++;
      if (obusy) nbusy++;
      if (odds_freq !== 32'h0ABC_0000) fbad++;
    end
    total++; if (nval != 0 || nbusy != 0 || fbad != 0) begin
      bad++; $display("FAIL abort_after got v=%0d b=%0d f=%0d want 0/0/0", nval, nbusy, fbad); end
    // A command coinciding with abort must be dropped even when the buffer is free.
    iabort = 1'b1; icmd_val = 1'b1; icmd_freq = 32'h1111_0000; icmd_len = 16'd3;
    tick();
    iabort = 1'b0; icmd_val = 1'b0;
    total++; if (ocmd_rdy !== 1'b1) begin bad++; $display("FAIL abort_drop_rdy got %b want 1", ocmd_rdy); end
    nval = 0; fbad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ovalid) nval++;
      if (odds_freq !== 32'h0ABC_0000) fbad++;
    end
    total++; if (nval != 0 || fbad != 0) begin
      bad++; $display("FAIL abort_drop got v=%0d f=%0d want 0/0", nval, fbad); end
  endtask

  task automatic test_stall();
    int nval = 0, sbad = 0;
    logic [3:0] snap_f = '0;
    logic snap_r = 1'b0;
    logic [FW-1:0] snap_q = '0;
    wait_idle();
    send(32'h0200_0000, 32'h100, 16'd6, 15'h0, 15'h0);
    for (int k = 1; k <= 30; k++) begin
      iclkena = !(k >= 10 && k <= 14);
      tick();
      if (k == 9) begin snap_f = {ovalid, osop, oeop, obusy}; snap_r = ocmd_rdy; snap_q = odds_freq; end
      if (!iclkena) begin
        if ({ovalid, osop, oeop, obusy} !== snap_f || ocmd_rdy !== snap_r || odds_freq !== snap_q) sbad++;
        if (odds_clkena !== 1'b0) sbad++;
      end else if (ovalid) nval++;
    end
    iclkena = 1'b1;
    total++; if (snap_f[3] !== 1'b1) begin bad++; $display("FAIL stall_mid got valid=%b want 1", snap_f[3]); end
    total++; if (sbad != 0) begin bad++; $display("FAIL stall_frozen got %0d diffs want 0", sbad); end
    total++; if (nval != 6) begin bad++; $display("FAIL stall_count got %0d want 6", nval); end
  endtask

  task automatic test_reset_mid();
    int w = 0, nval = 0;
    wait_idle();
    send(32'h0300_0000, 32'h0, 16'd50, 15'h0AAA, 15'h0555);
    while (!ovalid && w < 20) begin tick(); w++; end
    total++; if (ovalid !== 1'b1) begin bad++; $display("FAIL rstmid_run got %b want 1", ovalid); end
    ireset_n = 1'b0;
    #1;
    total++; if ({ovalid, osop, oeop, obusy, ocmd_rdy} !== 5'b00001) begin
      bad++; $display("FAIL rstmid_flags got %b want 00001", {ovalid, osop, oeop, obusy, ocmd_rdy}); end
    total++; if (odds_freq !== '0 || odds_ph_cos !== '0 || odds_ph_sin !== '0) begin
      bad++; $display("FAIL rstmid_regs got %h/%h/%h want 0", odds_freq, odds_ph_cos, odds_ph_sin); end
    tick(); tick();
    ireset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ovalid || obusy) nval++;
    end
    total++; if (nval != 0) begin bad++; $display("FAIL rstmid_stray got %0d want 0", nval); end
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_chirp();
    test_back_to_back();
    test_zero_len();
    test_abort();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
